// File: rtl/reg_write_arb.sv
// reg_write_arb
//   Merges two register-file writeback streams (A = ALU, B = load) onto a
//   single register-file write port. Each requester owns a one-entry holding
//   buffer. Ready depends only on registered state, so there is no
//   combinational path from valid to ready.
//
//   Arbitration when both buffers are full:
//     - equal addresses   : the older entry wins, so write-after-write order holds
//     - different address : round-robin on a 1-bit pointer, or B always wins
//                           when REG_WRITE_ARB_FIXED_PRIO_EN is defined
//   A lone full buffer is always granted.
//
// Ports
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   valid_a_i/addr_a_i/data_a_i, ready_a_o   requester A handshake
//   valid_b_i/addr_b_i/data_b_i, ready_b_o   requester B handshake
//   write_en_o/waddr_o/data_in_o             register-file write port
//   busy_o                   high while either buffer holds an entry
//
// Configuration macro: REG_WRITE_ARB_FIXED_PRIO_EN (B wins contention)
module reg_write_arb #(
   parameter int W = 8,
   parameter int D = 2
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         valid_a_i,
   input  logic [D-1:0] addr_a_i,
   input  logic [W-1:0] data_a_i,
   output logic         ready_a_o,
   input  logic         valid_b_i,
   input  logic [D-1:0] addr_b_i,
   input  logic [W-1:0] data_b_i,
   output logic         ready_b_o,
   output logic         write_en_o,
   output logic [D-1:0] waddr_o,
   output logic [W-1:0] data_in_o,
   output logic         busy_o
);

   logic         full_a_q, full_a_d;
   logic         full_b_q, full_b_d;
   logic [D-1:0] addr_a_q, addr_b_q;
   logic [W-1:0] data_a_q, data_b_q;
   logic         a_older_q, a_older_d;

   logic both_full, same_addr;
   logic grant_a, grant_b;
   logic load_a, load_b;
   logic retain_a, retain_b;

   assign both_full = full_a_q & full_b_q;
   assign same_addr = (addr_a_q == addr_b_q);

`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
   // B wins contention unless A holds the older write to the same register.
   assign grant_a = both_full ? (same_addr & a_older_q) : full_a_q;
`else
   // ptr_q: 0 = A has priority on the next contended grant, 1 = B.
   logic ptr_q, ptr_d;

   assign grant_a = both_full ? (same_addr ? a_older_q : ~ptr_q) : full_a_q;

   always_comb begin
      ptr_d = ptr_q;
      if (both_full) ptr_d = grant_a;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) ptr_q <= 1'b0;
      else          ptr_q <= ptr_d;
   end
`endif

   assign grant_b = full_b_q & ~grant_a;

   assign ready_a_o = ~full_a_q | grant_a;
   assign ready_b_o = ~full_b_q | grant_b;

   assign load_a = valid_a_i & ready_a_o;
   assign load_b = valid_b_i & ready_b_o;

   // A buffer that stays full without being granted keeps its old entry and
   // is therefore older than anything loaded alongside it.
   assign retain_a = full_a_q & ~grant_a;
   assign retain_b = full_b_q & ~grant_b;

   assign full_a_d = load_a | retain_a;
   assign full_b_d = load_b | retain_b;

   always_comb begin
      a_older_d = 1'b1;
      if (retain_a && retain_b) a_older_d = a_older_q;
      else if (retain_b)        a_older_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         full_a_q  <= 1'b0;
         full_b_q  <= 1'b0;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         data_a_q  <= '0;
         data_b_q  <= '0;
         a_older_q <= 1'b1;
      end else begin
         full_a_q  <= full_a_d;
         full_b_q  <= full_b_d;
         a_older_q <= a_older_d;
         if (load_a) begin
            addr_a_q <= addr_a_i;
            data_a_q <= data_a_i;
         end
         if (load_b) begin
            addr_b_q <= addr_b_i;
            data_b_q <= data_b_i;
         end
      end
   end

   assign write_en_o = full_a_q | full_b_q;
   assign busy_o     = full_a_q | full_b_q;

   always_comb begin
      waddr_o   = '0;
      data_in_o = '0;
      if (grant_a) begin
         waddr_o   = addr_a_q;
         data_in_o = data_a_q;
      end else if (grant_b) begin
         waddr_o   = addr_b_q;
         data_in_o = data_b_q;
      end
   end

endmodule

// File: tb/tb_reg_write_arb.sv
// Directed testbench for reg_write_arb (W=8, D=2).
// Inputs are driven 1 time unit after the rising edge; outputs are checked in
// the same window, where they reflect only the registered state.
module tb_reg_write_arb;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       valid_a_i, valid_b_i;
   logic [1:0] addr_a_i, addr_b_i;
   logic [7:0] data_a_i, data_b_i;
   logic       ready_a_o, ready_b_o;
   logic       write_en_o;
   logic [1:0] waddr_o;
   logic [7:0] data_in_o;
   logic       busy_o;

   int checks   = 0;
   int failures = 0;

   reg_write_arb #(.W(8), .D(2)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .valid_a_i  (valid_a_i),
      .addr_a_i   (addr_a_i),
      .data_a_i   (data_a_i),
      .ready_a_o  (ready_a_o),
      .valid_b_i  (valid_b_i),
      .addr_b_i   (addr_b_i),
      .data_b_i   (data_b_i),
      .ready_b_o  (ready_b_o),
      .write_en_o (write_en_o),
      .waddr_o    (waddr_o),
      .data_in_o  (data_in_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      valid_a_i = 1'b0; addr_a_i = 2'd0; data_a_i = 8'h00;
      valid_b_i = 1'b0; addr_b_i = 2'd0; data_b_i = 8'h00;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n_i = 1'b0;
      #3;
      checks++;
      if ({write_en_o, waddr_o, data_in_o, busy_o, ready_a_o, ready_b_o} !== 14'b0_00_00000000_0_1_1) begin
         failures++;
         $display("FAIL reset_outputs we=%b waddr=%0d data=%h busy=%b ra=%b rb=%b expected 0 0 00 0 1 1",
                  write_en_o, waddr_o, data_in_o, busy_o, ready_a_o, ready_b_o);
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      tick();
      checks++;
      if (write_en_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle we=%b busy=%b expected 0 0", write_en_o, busy_o);
      end
   endtask

   task automatic test_lone_a();
      logic       exp_we;
      logic [7:0] exp_data;
      for (int i = 0; i < 6; i++) begin
         valid_a_i = (i < 4);
         addr_a_i  = 2'd1;
         data_a_i  = 8'h11 + 8'(i);
         exp_we    = (i >= 1 && i <= 4);
         exp_data  = exp_we ? 8'h11 + 8'(i - 1) : 8'h00;
         checks++;
         if (write_en_o !== exp_we || data_in_o !== exp_data || waddr_o !== (exp_we ? 2'd1 : 2'd0)) begin
            failures++;
            $display("FAIL lone_a_write cyc=%0d we=%b waddr=%0d data=%h expected %b %0d %h",
                     i, write_en_o, waddr_o, data_in_o, exp_we, exp_we ? 1 : 0, exp_data);
         end
         checks++;
         if (ready_a_o !== 1'b1 || busy_o !== exp_we) begin
            failures++;
            $display("FAIL lone_a_ready cyc=%0d ra=%b busy=%b expected 1 %b", i, ready_a_o, busy_o, exp_we);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_waw();
      valid_b_i = 1'b1; addr_b_i = 2'd3; data_b_i = 8'hBB;
      tick();
      valid_b_i = 1'b0;
      valid_a_i = 1'b1; addr_a_i = 2'd3; data_a_i = 8'hAA;
      checks++;
      if (write_en_o !== 1'b1 || waddr_o !== 2'd3 || data_in_o !== 8'hBB) begin
         failures++;
         $display("FAIL waw_first we=%b waddr=%0d data=%h expected 1 3 bb", write_en_o, waddr_o, data_in_o);
      end
      tick();
      valid_a_i = 1'b0;
      checks++;
      if (write_en_o !== 1'b1 || waddr_o !== 2'd3 || data_in_o !== 8'hAA) begin
         failures++;
         $display("FAIL waw_second we=%b waddr=%0d data=%h expected 1 3 aa", write_en_o, waddr_o, data_in_o);
      end
      tick();
      checks++;
      if (write_en_o !== 1'b0) begin
         failures++;
         $display("FAIL waw_drained we=%b expected 0", write_en_o);
      end
      idle_inputs();
   endtask

   // Both requesters valid every cycle with different addresses; ends with
   // both buffers full so the mid-stream reset test can follow directly.
   task automatic test_contention();
      logic [7:0] ia, ib;
      logic       acc_a, acc_b, exp_ga;
      logic [7:0] exp_data;
      ia = 8'd0; ib = 8'd0;
      for (int i = 0; i < 5; i++) begin
         valid_a_i = 1'b1; addr_a_i = 2'd1; data_a_i = 8'hA0 + ia;
         valid_b_i = 1'b1; addr_b_i = 2'd2; data_b_i = 8'hB0 + ib;
         if (i == 0) begin
            checks++;
            if (write_en_o !== 1'b0 || ready_a_o !== 1'b1 || ready_b_o !== 1'b1) begin
               failures++;
               $display("FAIL cont_load we=%b ra=%b rb=%b expected 0 1 1", write_en_o, ready_a_o, ready_b_o);
            end
         end else begin
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
            exp_ga   = 1'b0;
            exp_data = 8'hB0 + 8'(i - 1);
`else
            exp_ga   = (i % 2 == 1);
            exp_data = exp_ga ? 8'hA0 + 8'((i - 1) / 2) : 8'hB0 + 8'((i - 1) / 2);
`endif
            checks++;
            if (write_en_o !== 1'b1 || waddr_o !== (exp_ga ? 2'd1 : 2'd2) || data_in_o !== exp_data) begin
               failures++;
               $display("FAIL cont_write cyc=%0d we=%b waddr=%0d data=%h expected 1 %0d %h",
                        i, write_en_o, waddr_o, data_in_o, exp_ga ? 1 : 2, exp_data);
            end
            checks++;
            if (ready_a_o !== exp_ga || ready_b_o !== ~exp_ga || busy_o !== 1'b1) begin
               failures++;
               $display("FAIL cont_ready cyc=%0d ra=%b rb=%b busy=%b expected %b %b 1",
                        i, ready_a_o, ready_b_o, busy_o, exp_ga, ~exp_ga);
            end
         end
         acc_a = ready_a_o;
         acc_b = ready_b_o;
         tick();
         if (acc_a) ia++;
         if (acc_b) ib++;
      end
   endtask

   task automatic test_reset_mid();
      checks++;
      if (busy_o !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre busy=%b expected 1", busy_o);
      end
      #1;
      rst_n_i = 1'b0;
      #1;
      checks++;
      if ({write_en_o, waddr_o, data_in_o, busy_o, ready_a_o, ready_b_o} !== 14'b0_00_00000000_0_1_1) begin
         failures++;
         $display("FAIL rst_mid_async we=%b waddr=%0d data=%h busy=%b ra=%b rb=%b expected 0 0 00 0 1 1",
                  write_en_o, waddr_o, data_in_o, busy_o, ready_a_o, ready_b_o);
      end
      idle_inputs();
      @(negedge clk_i);
      rst_n_i = 1'b1;
      tick();
      checks++;
      if (write_en_o !== 1'b0 || busy_o !== 1'b0 || ready_a_o !== 1'b1 || ready_b_o !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_idle we=%b busy=%b ra=%b rb=%b expected 0 0 1 1",
                  write_en_o, busy_o, ready_a_o, ready_b_o);
      end
   endtask

   // Skew the round-robin pointer toward B first, so an equal-address pair
   // loaded together must still drain A before B.
   task automatic test_same_cycle();
      valid_a_i = 1'b1; addr_a_i = 2'd1; data_a_i = 8'h33;
      valid_b_i = 1'b1; addr_b_i = 2'd2; data_b_i = 8'h44;
      tick();
      idle_inputs();
      tick();
      tick();
      checks++;
      if (write_en_o !== 1'b0) begin
         failures++;
         $display("FAIL same_setup_drain we=%b expected 0", write_en_o);
      end
      valid_a_i = 1'b1; addr_a_i = 2'd2; data_a_i = 8'h01;
      valid_b_i = 1'b1; addr_b_i = 2'd2; data_b_i = 8'h02;
      tick();
      idle_inputs();
      checks++;
      if (write_en_o !== 1'b1 || waddr_o !== 2'd2 || data_in_o !== 8'h01 || ready_a_o !== 1'b1 || ready_b_o !== 1'b0) begin
         failures++;
         $display("FAIL same_first we=%b waddr=%0d data=%h ra=%b rb=%b expected 1 2 01 1 0",
                  write_en_o, waddr_o, data_in_o, ready_a_o, ready_b_o);
      end
      tick();
      checks++;
      if (write_en_o !== 1'b1 || waddr_o !== 2'd2 || data_in_o !== 8'h02) begin
         failures++;
         $display("FAIL same_second we=%b waddr=%0d data=%h expected 1 2 02", write_en_o, waddr_o, data_in_o);
      end
      tick();
      checks++;
      if (write_en_o !== 1'b0 || waddr_o !== 2'd0 || data_in_o !== 8'h00) begin
         failures++;
         $display("FAIL same_drained we=%b waddr=%0d data=%h expected 0 0 00", write_en_o, waddr_o, data_in_o);
      end
   endtask

   initial begin
      test_reset();
      test_lone_a();
      test_waw();
      test_contention();
      test_reset_mid();
      test_same_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
